midi_uart_cmd_bridge: RTL and testbench
=======================================

// Module: midi_uart_cmd_bridge
// PURPOSE
//  Upstream feeder for the synthesizer top. Receives a serial MIDI stream (31250 baud, 8N1) and
//  parses Note On/Off, All-Notes-Off and Program Change messages. Emits each one as a one-cycle
//  write of the synth 16-bit command word {on, note[6:0], velocity[7:0]}, zero-extended to 32 bits.
//  Drives the synth avs_s0_write/avs_s0_writedata directly, with no CPU on the path.
// PARAMETERS
//  CLKS_PER_BIT  1600  clk cycles per UART bit (50 MHz / 31250); must be even and >= 8
//  OMNI          1     1: accept all MIDI channels; 0: accept only MIDI_CHANNEL
//  MIDI_CHANNEL  0     channel (0..15) accepted when OMNI=0
// PORTS
//  clk              in   1   system clock; single clock domain
//  reset            in   1   synchronous, active-high
//  i_midi_rx        in   1   asynchronous serial input, idles high
//  o_avm_write      out  1   one-cycle command strobe to synth avs_s0_write
//  o_avm_writedata  out  32  {16'h0000, cmd[15:0]}, held stable between strobes
//  o_framing_error  out  1   sticky; set when a stop bit samples low
//  o_cmd_count      out  16  number of strobes issued, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: on any clk edge with reset=1, all outputs go to 0, the UART returns to IDLE, running
//   status is cleared and any partial message is discarded.
//  Synchronizer: i_midi_rx passes through a 2-FF synchronizer. All UART logic uses the synced bit.
//  UART FSM IDLE->START->DATA->STOP->IDLE
//   - IDLE->START: on a synced high->low transition.
//   - START: wait CLKS_PER_BIT/2, then resample. High is treated as a glitch: return to IDLE.
//   - DATA: sample 8 bits LSB first, each CLKS_PER_BIT apart.
//   - STOP: sample once more after CLKS_PER_BIT. High: byte_valid pulses 1 cycle (cycle S).
//     Low: byte dropped and o_framing_error set.
//   - The FSM returns to IDLE one cycle after the stop sample.
//  Parser (acts on byte_valid)
//   - 0xF8-0xFF (real-time): ignored; parser state untouched.
//   - 0xF0-0xF7: clear running status and wait for a new status byte.
//   - 0x80-0xEF: latch status. Any partial message is abandoned; expect data byte 1.
//   - Message lengths: 0x8n/0x9n/0xBn take 2 data bytes. 0xCn takes 1. 0xAn/0xDn/0xEn take
//     their bytes but produce no output.
//   - Data byte with no running status: ignored.
//   - After a complete message, running status is kept; the next data byte is data byte 1.
//   - Channel mismatch (OMNI=0): the message is parsed but produces no output.
//  Command mapping (v = velocity, k = note)
//   - 0x9n k v, v!=0       -> 16'h8000 | k<<8 | v
//   - 0x9n k 0 or 0x8n k x -> k<<8 (stop)
//   - Notes k=0 and k=127 are reserved synth codes; messages with those notes are dropped.
//   - 0xBn 120|123 x       -> 16'h7F00 (STOP_ALL); other controllers are dropped.
//   - 0xCn p               -> 16'h8000 (wave toggle)
//  Strobe timing
//   - o_avm_write is high exactly during cycle S+1 of the completing byte.
//   - o_avm_writedata updates in the same cycle and holds until the next strobe.
//   - o_cmd_count increments in the same cycle.
//   - At most one strobe per received byte, so no back-pressure is needed.
//  Framing error: sticky until reset; parser state is unchanged by the bad byte.
// TESTING (bench uses CLKS_PER_BIT=16; UART bytes driven by a bit-banging task)
//  1. 0x90 0x45 0x64 -> one strobe, writedata 32'h0000C564; o_cmd_count=1.
//  2. 0x90 0x3C 0x40 0x3C 0x00 -> strobes 0xBC40 then 0x3C00 (running status; vel 0 = stop).
//  3. 0x80 0x45 0x7F -> 0x4500; 0xB0 0x7B 0x00 -> 0x7F00; 0xC0 0x05 -> 0x8000;
//     0x90 0x00 0x40 -> no strobe.
//  4. 0x90 0xF8 0x45 0xFE 0x64 -> single 0xC564. A lone 0x45 after reset -> no strobe.
//     A 5-cycle low glitch on rx -> no byte.
//  5. Byte with stop bit driven low -> no strobe, o_framing_error=1. A following valid
//     0x90 0x45 0x64 still strobes 0xC564.
//  6. 0x90 0x45, pulse reset, 0x64 -> no strobe, all outputs 0.
//     With OMNI=0, MIDI_CHANNEL=0: 0x91 0x45 0x64 -> no strobe.

Source files
------------

// File: rtl/midi_uart_cmd_bridge.sv
// MIDI UART receiver and message parser that writes synth command words directly
// onto the synth's Avalon slave write port, one strobe per completed message.
`timescale 1ns/1ps
module midi_uart_cmd_bridge #(
   parameter int unsigned CLKS_PER_BIT = 1600,
   parameter bit          OMNI         = 1'b1,
   parameter int unsigned MIDI_CHANNEL = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_midi_rx,
   output logic        o_avm_write,
   output logic [31:0] o_avm_writedata,
   output logic        o_framing_error,
   output logic [15:0] o_cmd_count
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } uart_state_e;

   // synchronizer and edge-history flops
   logic rx_meta_q, rx_sync_q, rx_prev_q;

   // UART receiver state
   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_valid_q, byte_valid_d;
   logic             framing_q, framing_d;

   // parser state and registered outputs
   logic        run_q, run_d;
   logic [7:0]  status_q, status_d;
   logic        have_d1_q, have_d1_d;
   logic [6:0]  d1_q, d1_d;
   logic        write_q, write_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] count_q, count_d;

   logic        emit_c;
   logic [15:0] cmd_c;
   logic [3:0]  status_hi_c;
   logic        two_bytes_c, chan_ok_c, note_ok_c, stop_ctl_c;

   assign status_hi_c = status_q[7:4];
   assign two_bytes_c = !((status_hi_c == 4'hC) || (status_hi_c == 4'hD));
   assign chan_ok_c   = OMNI || (status_q[3:0] == 4'(MIDI_CHANNEL));
   assign note_ok_c   = (d1_q != 7'd0) && (d1_q != 7'd127);
   assign stop_ctl_c  = (d1_q == 7'd120) || (d1_q == 7'd123);

   // bring the asynchronous rx line into the clk domain; idle level is high
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= i_midi_rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // UART and parser state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         framing_q    <= 1'b0;
         run_q        <= 1'b0;
         status_q     <= '0;
         have_d1_q    <= 1'b0;
         d1_q         <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         framing_q    <= framing_d;
         run_q        <= run_d;
         status_q     <= status_d;
         have_d1_q    <= have_d1_d;
         d1_q         <= d1_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         count_q      <= count_d;
      end
   end

   // UART next state: start-bit qualification at half a bit, then bit-centre sampling
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      framing_d    = framing_q;
      case (state_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_sync_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d     = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (rx_sync_q) begin
                  byte_valid_d = 1'b1;
               end else begin
                  framing_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // parser: running status, data-byte collection and command mapping
   always_comb begin
      run_d     = run_q;
      status_d  = status_q;
      have_d1_d = have_d1_q;
      d1_d      = d1_q;
      write_d   = 1'b0;
      wdata_d   = wdata_q;
      count_d   = count_q;
      emit_c    = 1'b0;
      cmd_c     = '0;
      // real-time bytes 0xF8-0xFF fall through untouched
      if (byte_valid_q && (shift_q[7:3] != 5'b11111)) begin
         if (shift_q[7:4] == 4'hF) begin
            run_d     = 1'b0;
            have_d1_d = 1'b0;
         end else if (shift_q[7]) begin
            run_d     = 1'b1;
            status_d  = shift_q;
            have_d1_d = 1'b0;
         end else if (run_q) begin
            if (two_bytes_c && !have_d1_q) begin
               d1_d      = shift_q[6:0];
               have_d1_d = 1'b1;
            end else begin
               have_d1_d = 1'b0;
               if (chan_ok_c) begin
                  case (status_hi_c)
                     4'h9: begin
                        emit_c = note_ok_c;
                        cmd_c  = (shift_q != 8'h00) ? {1'b1, d1_q, shift_q} : {1'b0, d1_q, 8'h00};
                     end
                     4'h8: begin
                        emit_c = note_ok_c;
                        cmd_c  = {1'b0, d1_q, 8'h00};
                     end
                     4'hB: begin
                        emit_c = stop_ctl_c;
                        cmd_c  = 16'h7F00;
                     end
                     4'hC: begin
                        emit_c = 1'b1;
                        cmd_c  = 16'h8000;
                     end
                     default: emit_c = 1'b0;
                  endcase
               end
            end
         end
      end
      if (emit_c) begin
         write_d = 1'b1;
         wdata_d = cmd_c;
         count_d = count_q + 16'd1;
      end
   end

   assign o_avm_write     = write_q;
   assign o_avm_writedata = {16'h0000, wdata_q};
   assign o_framing_error = framing_q;
   assign o_cmd_count     = count_q;

endmodule

// File: tb/tb_midi_uart_cmd_bridge.sv
// Bench for midi_uart_cmd_bridge: two instances (omni and channel-0 only) share one
// rx line; a message-level MIDI model predicts the command stream of each.
`timescale 1ns/1ps
module tb_midi_uart_cmd_bridge;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic        w0, w1, fe0, fe1;
   logic [31:0] wd0, wd1;
   logic [15:0] cnt0, cnt1;

   int errors = 0;
   int checks = 0;

   // expected command words per instance, and model state
   logic [15:0] exp0[$];
   logic [15:0] exp1[$];
   int          m_stat[2];
   int          m_nd[2];
   int          m_d1[2];
   int          m_cnt[2];
   logic [15:0] m_last[2];
   logic [15:0] e0, e1;

   always #5 clk = ~clk;

   midi_uart_cmd_bridge #(.CLKS_PER_BIT(CPB), .OMNI(1'b1), .MIDI_CHANNEL(0)) dut (
      .clk(clk), .reset(reset), .i_midi_rx(rx),
      .o_avm_write(w0), .o_avm_writedata(wd0), .o_framing_error(fe0), .o_cmd_count(cnt0));

   midi_uart_cmd_bridge #(.CLKS_PER_BIT(CPB), .OMNI(1'b0), .MIDI_CHANNEL(0)) dut_ch (
      .clk(clk), .reset(reset), .i_midi_rx(rx),
      .o_avm_write(w1), .o_avm_writedata(wd1), .o_framing_error(fe1), .o_cmd_count(cnt1));

   // each strobe must match the oldest outstanding expected command
   always @(negedge clk) begin
      if (w0 === 1'b1) begin
         checks++;
         if (exp0.size() == 0) begin
            errors++;
            $display("FAIL strobe_omni: unexpected strobe data %h", wd0);
         end else begin
            e0 = exp0.pop_front();
            if (wd0 !== {16'h0000, e0}) begin
               errors++;
               $display("FAIL strobe_omni: got %h expected %h", wd0, {16'h0000, e0});
            end
         end
      end
      if (w1 === 1'b1) begin
         checks++;
         if (exp1.size() == 0) begin
            errors++;
            $display("FAIL strobe_ch0: unexpected strobe data %h", wd1);
         end else begin
            e1 = exp1.pop_front();
            if (wd1 !== {16'h0000, e1}) begin
               errors++;
               $display("FAIL strobe_ch0: got %h expected %h", wd1, {16'h0000, e1});
            end
         end
      end
   end

   // message-level MIDI model: one call per correctly framed byte
   task automatic model_byte(input int inst, input logic [7:0] b);
      int hi, need, k, v;
      logic [15:0] cmd;
      bit emit;
      if (b >= 8'hF8) return;
      if (b >= 8'hF0) begin m_stat[inst] = -1; m_nd[inst] = 0; return; end
      if (b >= 8'h80) begin m_stat[inst] = int'(b); m_nd[inst] = 0; return; end
      if (m_stat[inst] < 0) return;
      hi   = m_stat[inst] / 16;
      need = (hi == 12 || hi == 13) ? 1 : 2;
      if (need == 2 && m_nd[inst] == 0) begin m_d1[inst] = int'(b); m_nd[inst] = 1; return; end
      m_nd[inst] = 0;
      if (inst == 1 && (m_stat[inst] % 16) != 0) return;
      k = m_d1[inst];
      v = int'(b);
      emit = 1'b0;
      cmd = 16'h0;
      if (hi == 9 && k != 0 && k != 127) begin
         emit = 1'b1;
         cmd = (v != 0) ? 16'(32768 + k * 256 + v) : 16'(k * 256);
      end else if (hi == 8 && k != 0 && k != 127) begin
         emit = 1'b1;
         cmd = 16'(k * 256);
      end else if (hi == 11 && (k == 120 || k == 123)) begin
         emit = 1'b1;
         cmd = 16'h7F00;
      end else if (hi == 12) begin
         emit = 1'b1;
         cmd = 16'h8000;
      end
      if (emit) begin
         if (inst == 0) exp0.push_back(cmd);
         else exp1.push_back(cmd);
         m_cnt[inst] = (m_cnt[inst] + 1) % 65536;
         m_last[inst] = cmd;
      end
   endtask

   // bit-bang one 8N1 frame; a bad stop bit means the byte must not reach the parser
   task automatic send_byte(input logic [7:0] b, input int gap, input bit bad_stop);
      if (!bad_stop) begin
         model_byte(0, b);
         model_byte(1, b);
      end
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = ~bad_stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_seq(input logic [7:0] s[], input int gap);
      foreach (s[i]) send_byte(s[i], gap, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_stat[i] = -1; m_nd[i] = 0; m_d1[i] = 0; m_cnt[i] = 0; m_last[i] = 16'h0;
      end
      exp0.delete();
      exp1.delete();
   endtask

   // bounded wait for outstanding strobes
   task automatic drain();
      int n = 0;
      while ((exp0.size() != 0 || exp1.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({w0, wd0, fe0, cnt0} !== 50'h0) begin
         errors++;
         $display("FAIL reset_omni: got %b/%h/%b/%h expected all zero", w0, wd0, fe0, cnt0);
      end
      checks++;
      if ({w1, wd1, fe1, cnt1} !== 50'h0) begin
         errors++;
         $display("FAIL reset_ch0: got %b/%h/%b/%h expected all zero", w1, wd1, fe1, cnt1);
      end
   endtask

   task automatic test_note_on();
      logic [7:0] s[] = '{8'h90, 8'h45, 8'h64};
      send_seq(s, 20);
      drain();
      checks++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         errors++;
         $display("FAIL note_on_pending: got %0d/%0d missing strobes expected 0", exp0.size(), exp1.size());
      end
      checks++;
      if (wd0 !== 32'h0000C564) begin
         errors++;
         $display("FAIL note_on_data: got %h expected 0000c564", wd0);
      end
      checks++;
      if (cnt0 !== 16'd1 || cnt1 !== 16'd1) begin
         errors++;
         $display("FAIL note_on_count: got %0d/%0d expected 1/1", cnt0, cnt1);
      end
      checks++;
      if (fe0 !== 1'b0) begin
         errors++;
         $display("FAIL note_on_ferr: got %b expected 0", fe0);
      end
   endtask

   task automatic test_running_status();
      logic [7:0] s[] = '{8'h90, 8'h3C, 8'h40, 8'h3C, 8'h00};
      send_seq(s, 10);
      drain();
      checks++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         errors++;
         $display("FAIL running_pending: got %0d/%0d missing strobes expected 0", exp0.size(), exp1.size());
      end
      checks++;
      if (wd0 !== 32'h00003C00 || cnt0 !== 16'd3) begin
         errors++;
         $display("FAIL running_last: got %h cnt %0d expected 00003c00 cnt 3", wd0, cnt0);
      end
   endtask

   task automatic test_mapping();
      logic [7:0] s[] = '{8'h80, 8'h45, 8'h7F, 8'hB0, 8'h7B, 8'h00, 8'hC0, 8'h05,
                          8'h90, 8'h00, 8'h40, 8'hB0, 8'h07, 8'h10};
      send_seq(s, 5);
      drain();
      checks++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         errors++;
         $display("FAIL mapping_pending: got %0d/%0d missing strobes expected 0", exp0.size(), exp1.size());
      end
      checks++;
      if (wd0 !== 32'h00008000 || cnt0 !== 16'd6) begin
         errors++;
         $display("FAIL mapping_last: got %h cnt %0d expected 00008000 cnt 6", wd0, cnt0);
      end
   endtask

   task automatic test_realtime_glitch();
      logic [7:0] s[] = '{8'h90, 8'hF8, 8'h45, 8'hFE, 8'h64};
      logic [7:0] t[] = '{8'h90, 8'h45, 8'h64};
      send_seq(s, 3);
      drain();
      checks++;
      if (wd0 !== 32'h0000C564 || cnt0 !== 16'(m_cnt[0])) begin
         errors++;
         $display("FAIL realtime: got %h cnt %0d expected 0000c564 cnt %0d", wd0, cnt0, m_cnt[0]);
      end
      do_reset();
      send_byte(8'h45, 20, 1'b0);
      drain();
      checks++;
      if (cnt0 !== 16'd0 || w0 !== 1'b0) begin
         errors++;
         $display("FAIL lone_data: got cnt %0d expected 0", cnt0);
      end
      @(negedge clk);
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      send_seq(t, 5);
      drain();
      checks++;
      if (exp0.size() != 0 || wd0 !== 32'h0000C564 || cnt0 !== 16'd1 || fe0 !== 1'b0) begin
         errors++;
         $display("FAIL glitch: got %h cnt %0d ferr %b expected 0000c564 cnt 1 ferr 0", wd0, cnt0, fe0);
      end
   endtask

   task automatic test_framing();
      send_byte(8'h45, 10, 1'b0);
      send_byte(8'h80, 30, 1'b1);
      send_byte(8'h64, 10, 1'b0);
      drain();
      checks++;
      if (fe0 !== 1'b1 || fe1 !== 1'b1) begin
         errors++;
         $display("FAIL framing_flag: got %b/%b expected 1/1", fe0, fe1);
      end
      checks++;
      if (exp0.size() != 0 || wd0 !== 32'h0000C564 || cnt0 !== 16'd2) begin
         errors++;
         $display("FAIL framing_parser: got %h cnt %0d expected 0000c564 cnt 2", wd0, cnt0);
      end
   endtask

   task automatic test_reset_mid();
      send_byte(8'h90, 5, 1'b0);
      send_byte(8'h45, 5, 1'b0);
      do_reset();
      send_byte(8'h64, 20, 1'b0);
      drain();
      checks++;
      if ({w0, wd0, fe0, cnt0} !== 50'h0 || {w1, wd1, fe1, cnt1} !== 50'h0) begin
         errors++;
         $display("FAIL reset_mid: got %h cnt %0d ferr %b expected all zero", wd0, cnt0, fe0);
      end
   endtask

   task automatic test_channel_filter();
      logic [7:0] s[] = '{8'h91, 8'h45, 8'h64, 8'h90, 8'h3C, 8'h40};
      send_seq(s, 5);
      drain();
      checks++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         errors++;
         $display("FAIL channel_pending: got %0d/%0d missing strobes expected 0", exp0.size(), exp1.size());
      end
      checks++;
      if (cnt0 !== 16'd2 || cnt1 !== 16'd1 || wd1 !== 32'h0000BC40) begin
         errors++;
         $display("FAIL channel_filter: got cnt %0d/%0d data %h expected 2/1 0000bc40", cnt0, cnt1, wd1);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] s[] = '{8'hC3, 8'h10, 8'h92, 8'h30, 8'h50, 8'h30, 8'h00, 8'h80, 8'h22, 8'h01};
      send_seq(s, 0);
      drain();
      checks++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         errors++;
         $display("FAIL b2b_pending: got %0d/%0d missing strobes expected 0", exp0.size(), exp1.size());
      end
      checks++;
      if (cnt0 !== 16'(m_cnt[0]) || cnt1 !== 16'(m_cnt[1]) || wd1 !== {16'h0000, m_last[1]}) begin
         errors++;
         $display("FAIL b2b_state: got cnt %0d/%0d data %h expected %0d/%0d %h",
                  cnt0, cnt1, wd1, m_cnt[0], m_cnt[1], m_last[1]);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int r;
      int his[8] = '{8, 9, 9, 11, 12, 10, 13, 14};
      int specials[4] = '{0, 127, 120, 123};
      for (int n = 0; n < 70; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2) b = 8'(his[$urandom_range(0, 7)] * 16 + int'($urandom_range(0, 1)));
         else if (r == 2) b = 8'($urandom_range(240, 255));
         else if ($urandom_range(0, 4) == 0) b = 8'(specials[$urandom_range(0, 3)]);
         else b = 8'($urandom_range(0, 127));
         send_byte(b, int'($urandom_range(0, 20)), 1'b0);
      end
      drain();
      checks++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         errors++;
         $display("FAIL random_pending: got %0d/%0d missing strobes expected 0", exp0.size(), exp1.size());
      end
      checks++;
      if (cnt0 !== 16'(m_cnt[0]) || wd0 !== {16'h0000, m_last[0]}) begin
         errors++;
         $display("FAIL random_omni: got cnt %0d data %h expected %0d %h", cnt0, wd0, m_cnt[0], m_last[0]);
      end
      checks++;
      if (cnt1 !== 16'(m_cnt[1]) || wd1 !== {16'h0000, m_last[1]}) begin
         errors++;
         $display("FAIL random_ch0: got cnt %0d data %h expected %0d %h", cnt1, wd1, m_cnt[1], m_last[1]);
      end
   endtask

   initial begin
      test_reset();
      test_note_on();
      test_running_status();
      test_mapping();
      test_realtime_glitch();
      test_framing();
      test_reset_mid();
      test_channel_filter();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
